// File: rtl/f1_race_timer.sv
// F1 start-light sequencer: lamps fill on prescaler ticks, hold for a pseudo-random
// number of ticks, go dark, then the driver's reaction time is counted in clock cycles.
module f1_race_timer #(
    parameter int unsigned NUM_LIGHTS = 8,
    parameter int unsigned N_WIDTH    = 6,
    parameter int unsigned LFSR_WIDTH = 7,
    parameter int unsigned RT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_WIDTH-1:0]    N,
    input  logic                  trigger,
    input  logic                  react,
    output logic [NUM_LIGHTS-1:0] data_out,
    output logic                  cmd_seq,
    output logic                  cmd_delay,
    output logic [RT_WIDTH-1:0]   rt_count,
    output logic                  rt_valid,
    output logic                  false_start
);

    // Feedback tap masks (bit i set means register bit i feeds the XOR).
    localparam logic [7:0] TapMask =
        (LFSR_WIDTH == 4) ? 8'h0C :
        (LFSR_WIDTH == 5) ? 8'h14 :
        (LFSR_WIDTH == 6) ? 8'h30 :
        (LFSR_WIDTH == 7) ? 8'h44 : 8'hB8;
    localparam logic [LFSR_WIDTH-1:0] Taps = TapMask[LFSR_WIDTH-1:0];

    typedef enum logic [2:0] {StIdle, StSeq, StHold, StGo, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    trig_prev_q, react_prev_q;
    logic                    trig_edge, react_edge;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [N_WIDTH-1:0]      presc_q, presc_d;
    logic [LFSR_WIDTH-1:0]   hold_q, hold_d;
    logic [NUM_LIGHTS-1:0]   lamps_q, lamps_d;
    logic                    delay_q, delay_d;
    logic [RT_WIDTH-1:0]     rt_q, rt_d;
    logic                    valid_q, valid_d;
    logic                    fs_q, fs_d;
    logic                    tick;
    logic                    bar_full_next;
    logic                    hold_last;

    assign trig_edge     = trigger & ~trig_prev_q;
    assign react_edge    = react & ~react_prev_q;
    assign tick          = (presc_q == '0);
    // The next shift fills the bar when every lamp below the top one is already lit.
    assign bar_full_next = &lamps_q[NUM_LIGHTS-2:0];
    assign hold_last     = (hold_q == LFSR_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (trig_edge) state_d = StSeq;
            end
            StSeq: begin
                if (react_edge) begin
                    state_d = StIdle;
                end else if (tick && bar_full_next) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (react_edge) begin
                    state_d = StIdle;
                end else if (tick && hold_last) begin
                    state_d = StGo;
                end
            end
            StGo: begin
                if (react_edge) state_d = StDone;
            end
            StDone: begin
                if (trig_edge) state_d = StSeq;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lfsr_d  = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & Taps)};
        presc_d = presc_q;
        hold_d  = hold_q;
        lamps_d = lamps_q;
        delay_d = 1'b0;
        rt_d    = rt_q;
        valid_d = valid_q;
        fs_d    = fs_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (trig_edge) begin
                    presc_d = N;
                    lamps_d = '0;
                    rt_d    = '0;
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                end
            end
            StSeq: begin
                if (react_edge) begin
                    lamps_d = '0;
                    fs_d    = 1'b1;
                end else if (tick) begin
                    presc_d = N;
                    lamps_d = {lamps_q[NUM_LIGHTS-2:0], 1'b1};
                    if (bar_full_next) begin
                        hold_d  = lfsr_q;
                        delay_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q - N_WIDTH'(1);
                end
            end
            StHold: begin
                if (react_edge) begin
                    lamps_d = '0;
                    fs_d    = 1'b1;
                end else if (tick) begin
                    presc_d = N;
                    hold_d  = hold_q - LFSR_WIDTH'(1);
                    if (hold_last) begin
                        lamps_d = '0;
                        rt_d    = '0;
                    end
                end else begin
                    presc_d = presc_q - N_WIDTH'(1);
                end
            end
            StGo: begin
                // The edge that sees the press still counts, then the value freezes.
                if (rt_q != '1) rt_d = rt_q + RT_WIDTH'(1);
                if (react_edge) valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_prev_q  <= 1'b0;
            react_prev_q <= 1'b0;
            lfsr_q       <= LFSR_WIDTH'(1);
            presc_q      <= '0;
            hold_q       <= '0;
            lamps_q      <= '0;
            delay_q      <= 1'b0;
            rt_q         <= '0;
            valid_q      <= 1'b0;
            fs_q         <= 1'b0;
        end else begin
            trig_prev_q  <= trigger;
            react_prev_q <= react;
            lfsr_q       <= lfsr_d;
            presc_q      <= presc_d;
            hold_q       <= hold_d;
            lamps_q      <= lamps_d;
            delay_q      <= delay_d;
            rt_q         <= rt_d;
            valid_q      <= valid_d;
            fs_q         <= fs_d;
        end
    end

    always_comb begin
        data_out    = lamps_q;
        cmd_seq     = (state_q == StSeq);
        cmd_delay   = delay_q;
        rt_count    = rt_q;
        rt_valid    = valid_q;
        false_start = fs_q;
    end

endmodule
